// File: rtl/cram_axi_rd_slave.sv
// AXI4 read-only responder for the code RAM: walks AR bursts, reads a one-cycle-latency
// synchronous memory and returns R beats through a 2-entry buffer. Define CRAM_RD_WRAP_EN for WRAP bursts.
module cram_axi_rd_slave #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ID_W-1:0]   s_cram_arid,
  input  logic [31:0]       s_cram_araddr,
  input  logic [7:0]        s_cram_arlen,
  input  logic [2:0]        s_cram_arsize,
  input  logic [1:0]        s_cram_arburst,
  input  logic              s_cram_arvalid,
  output logic              s_cram_arready,
  output logic [ID_W-1:0]   s_cram_rid,
  output logic [DATA_W-1:0] s_cram_rdata,
  output logic [1:0]        s_cram_rresp,
  output logic              s_cram_rlast,
  output logic              s_cram_rvalid,
  input  logic              s_cram_rready,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, next_state;
  logic              ar_en_q;
  logic              ar_hs, ar_err, burst_err;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [7:0]        cnt_q;
  logic [1:0]        burst_q;
  logic              err_q;
`ifdef CRAM_RD_WRAP_EN
  logic [7:0]        len_q;
  logic [ADDR_W-1:0] wrap_mask;
`endif

  logic              issue, credit_ok, pop, pop_fifo, push;
  logic [2:0]        occupancy;

  logic              if_v, if_last, if_err;
  logic [ID_W-1:0]   if_id;
  logic [DATA_W-1:0] ret_data;

  logic [DATA_W-1:0] buf_data [2];
  logic [ID_W-1:0]   buf_id   [2];
  logic              buf_last [2];
  logic              buf_err  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  assign ar_hs = s_cram_arvalid && s_cram_arready;

  // Errored bursts still produce every beat, but never touch the memory.
  always_comb begin
`ifdef CRAM_RD_WRAP_EN
    burst_err = (s_cram_arburst == 2'd3) ||
                ((s_cram_arburst == 2'd2) &&
                 !((s_cram_arlen == 8'd1) || (s_cram_arlen == 8'd3) ||
                   (s_cram_arlen == 8'd7) || (s_cram_arlen == 8'd15)));
`else
    burst_err = s_cram_arburst[1];
`endif
    ar_err = (s_cram_arsize != 3'd2) || (s_cram_araddr[1:0] != 2'b00) ||
             (s_cram_araddr[31:ADDR_W] != '0) || burst_err;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ar_en_q <= 1'b0;
    end else begin
      state   <= next_state;
      ar_en_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ar_hs) next_state = BURST;
      BURST:   if (issue && (cnt_q == 8'd0)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_cram_arready = 1'b0;
    issue          = 1'b0;
    mem_en         = 1'b0;
    case (state)
      IDLE:  s_cram_arready = ar_en_q;
      BURST: begin
        issue  = credit_ok;
        mem_en = credit_ok && !err_q;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q[ADDR_W-1:2];

`ifdef CRAM_RD_WRAP_EN
  assign wrap_mask = ADDR_W'({len_q, 2'b11});
`endif

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      2'd1: addr_nxt = addr_q + ADDR_W'(4);
`ifdef CRAM_RD_WRAP_EN
      2'd2: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + ADDR_W'(4)) & wrap_mask);
`endif
      default: addr_nxt = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      id_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
`ifdef CRAM_RD_WRAP_EN
      len_q   <= '0;
`endif
    end else if (ar_hs) begin
      id_q    <= s_cram_arid;
      addr_q  <= s_cram_araddr[ADDR_W-1:0];
      cnt_q   <= s_cram_arlen;
      burst_q <= s_cram_arburst;
      err_q   <= ar_err;
`ifdef CRAM_RD_WRAP_EN
      len_q   <= s_cram_arlen;
`endif
    end else if (issue) begin
      addr_q <= addr_nxt;
      cnt_q  <= cnt_q - 8'd1;
    end
  end

  // The in-flight beat counts against buffer space so its data always has a slot.
  assign occupancy = {1'b0, count} + {2'b00, if_v} - {2'b00, pop};
  assign credit_ok = occupancy < 3'd2;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      if_v    <= 1'b0;
      if_last <= 1'b0;
      if_err  <= 1'b0;
      if_id   <= '0;
    end else begin
      if_v <= issue;
      if (issue) begin
        if_id   <= id_q;
        if_last <= (cnt_q == 8'd0);
        if_err  <= err_q;
      end
    end
  end

  assign ret_data = if_err ? '0 : mem_rdata;

  // With an empty buffer the returning beat is presented directly from memory.
  always_comb begin
    s_cram_rvalid = 1'b0;
    s_cram_rid    = '0;
    s_cram_rdata  = '0;
    s_cram_rresp  = 2'b00;
    s_cram_rlast  = 1'b0;
    if (count != 2'd0) begin
      s_cram_rvalid = 1'b1;
      s_cram_rid    = buf_id[rd_ptr];
      s_cram_rdata  = buf_data[rd_ptr];
      s_cram_rresp  = buf_err[rd_ptr] ? 2'b10 : 2'b00;
      s_cram_rlast  = buf_last[rd_ptr];
    end else if (if_v) begin
      s_cram_rvalid = 1'b1;
      s_cram_rid    = if_id;
      s_cram_rdata  = ret_data;
      s_cram_rresp  = if_err ? 2'b10 : 2'b00;
      s_cram_rlast  = if_last;
    end
  end

  assign pop      = s_cram_rvalid && s_cram_rready;
  assign pop_fifo = pop && (count != 2'd0);
  assign push     = if_v && !(pop && (count == 2'd0));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_id[i]   <= '0;
        buf_last[i] <= 1'b0;
        buf_err[i]  <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= ret_data;
        buf_id[wr_ptr]   <= if_id;
        buf_last[wr_ptr] <= if_last;
        buf_err[wr_ptr]  <= if_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule
